yin_tau_search: RTL and testbench

Tau-sweep controller and cumulative-mean-normalized threshold detector for the YIN pitch path. It sits directly downstream of the difference engine (`diff_module`). For each lag it drives `tau` and the per-lag `reset`, then captures the finished `accumulator` d(tau). It runs the CMND threshold test d'(tau) < THRESHOLD using cross-multiplication, with no divider, and reports the detected pitch period in samples.

---
 rtl/yin_tau_search.sv | 149 ++++++++++++++
 tb/tb_yin_tau_search.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/yin_tau_search.sv
// YIN tau sweep controller: drives the difference engine lag by lag and applies a divider-free CMND threshold test.
// Optional LOCAL_MIN_SEARCH_EN: after the first pass, keep descending to the local minimum of d'(tau).
module yin_tau_search #(
    parameter int ACC_WIDTH   = 39,
    parameter int TAU_WIDTH   = 6,
    parameter int MAX_TAU     = 40,
    parameter int ADDR_WIDTH  = 16,
    parameter int THRESH_FRAC = 8,
    parameter int THRESHOLD   = 26
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] frame_addr,
    output logic [ADDR_WIDTH-1:0] diff_initial_address,
    output logic [TAU_WIDTH-1:0]  diff_tau,
    output logic                  diff_reset,
    input  logic                  diff_ready,
    input  logic [ACC_WIDTH-1:0]  diff_accumulator,
    output logic                  busy,
    output logic                  done,
    output logic                  found,
    output logic [TAU_WIDTH-1:0]  tau_out
);

    localparam int SUM_W = ACC_WIDTH + TAU_WIDTH;
    localparam int CMP_W = SUM_W + THRESH_FRAC + 1;
    localparam logic [TAU_WIDTH-1:0] LAST_TAU = TAU_WIDTH'(MAX_TAU - 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, EVAL, DONE} state_t;

    state_t                 state, next_state;
    logic [SUM_W-1:0]       sum, s_new;
    logic [ACC_WIDTH-1:0]   d_cap;
    logic                   ready_prev;
    logic                   ready_rise;
    logic [CMP_W-1:0]       lhs, rhs;
    logic                   pass, take, finished, last;

`ifdef LOCAL_MIN_SEARCH_EN
    localparam int PROD_W = 2 * SUM_W;
    logic [ACC_WIDTH-1:0]   cand_d;
    logic [SUM_W-1:0]       cand_s;
    logic [PROD_W-1:0]      cur_metric, cand_metric;
    logic                   better;
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        diff_reset = 1'b1;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE:  if (start) next_state = ISSUE;
            ISSUE: begin
                busy       = 1'b1;
                next_state = WAIT;
            end
            WAIT: begin
                busy       = 1'b1;
                diff_reset = 1'b0;
                if (ready_rise) next_state = EVAL;
            end
            EVAL: begin
                busy       = 1'b1;
                diff_reset = 1'b0;
                next_state = (finished || last) ? DONE : ISSUE;
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // d'(tau) < T/2^F rewritten as (d*tau) << F < T*S so no divider is needed
    always_comb begin
        ready_rise = diff_ready && !ready_prev;
        last       = (diff_tau == LAST_TAU);
        s_new      = sum + SUM_W'(d_cap);
        lhs        = (CMP_W'(d_cap) * CMP_W'(diff_tau)) << THRESH_FRAC;
        rhs        = CMP_W'(THRESHOLD) * CMP_W'(s_new);
        pass       = (lhs < rhs) && !((d_cap == '0) && (s_new == '0));
`ifdef LOCAL_MIN_SEARCH_EN
        cur_metric  = PROD_W'(d_cap) * PROD_W'(diff_tau) * PROD_W'(cand_s);
        cand_metric = PROD_W'(cand_d) * PROD_W'(tau_out) * PROD_W'(s_new);
        better      = cur_metric < cand_metric;
        take        = found ? better : pass;
        finished    = found && !better;
`else
        take        = pass;
        finished    = pass;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            diff_initial_address <= '0;
            diff_tau             <= '0;
            sum                  <= '0;
            d_cap                <= '0;
            ready_prev           <= 1'b0;
            found                <= 1'b0;
            tau_out              <= '0;
`ifdef LOCAL_MIN_SEARCH_EN
            cand_d               <= '0;
            cand_s               <= '0;
`endif
        end else begin
            ready_prev <= diff_ready;
            case (state)
                IDLE: begin
                    if (start) begin
                        diff_initial_address <= frame_addr;
                        diff_tau             <= TAU_WIDTH'(1);
                        sum                  <= '0;
                        found                <= 1'b0;
                        tau_out              <= '0;
`ifdef LOCAL_MIN_SEARCH_EN
                        cand_d               <= '0;
                        cand_s               <= '0;
`endif
                    end
                end
                WAIT: if (ready_rise) d_cap <= diff_accumulator;
                EVAL: begin
                    sum <= s_new;
                    if (take) begin
                        found   <= 1'b1;
                        tau_out <= diff_tau;
`ifdef LOCAL_MIN_SEARCH_EN
                        cand_d  <= d_cap;
                        cand_s  <= s_new;
`endif
                    end
                    if (!finished && !last) diff_tau <= diff_tau + TAU_WIDTH'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_yin_tau_search.sv
// Self-checking bench for yin_tau_search: behavioural difference-engine responder plus a loop-based CMND reference model.
// Honours LOCAL_MIN_SEARCH_EN in the reference model so both builds are checked.
module tb_yin_tau_search;

    localparam int ACC_WIDTH   = 39;
    localparam int TAU_WIDTH   = 6;
    localparam int MAX_TAU     = 40;
    localparam int ADDR_WIDTH  = 16;
    localparam int THRESH_FRAC = 8;
    localparam int THRESHOLD   = 26;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  start = 1'b0;
    logic [ADDR_WIDTH-1:0] frame_addr = '0;
    logic [ADDR_WIDTH-1:0] diff_initial_address;
    logic [TAU_WIDTH-1:0]  diff_tau;
    logic                  diff_reset;
    logic                  diff_ready = 1'b0;
    logic [ACC_WIDTH-1:0]  diff_accumulator = '0;
    logic                  busy, done, found;
    logic [TAU_WIDTH-1:0]  tau_out;

    always #5 clk = ~clk;

    yin_tau_search #(
        .ACC_WIDTH(ACC_WIDTH), .TAU_WIDTH(TAU_WIDTH), .MAX_TAU(MAX_TAU),
        .ADDR_WIDTH(ADDR_WIDTH), .THRESH_FRAC(THRESH_FRAC), .THRESHOLD(THRESHOLD)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .frame_addr(frame_addr),
        .diff_initial_address(diff_initial_address), .diff_tau(diff_tau),
        .diff_reset(diff_reset), .diff_ready(diff_ready),
        .diff_accumulator(diff_accumulator), .busy(busy), .done(done),
        .found(found), .tau_out(tau_out)
    );

    int checks = 0;
    int fails  = 0;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Difference engine stand-in: after diff_reset drops, wait `latency` cycles, then
    // present d_tab[diff_tau] with diff_ready high for `hold_len` cycles.
    logic [ACC_WIDTH-1:0] d_tab [0:63];
    int latency  = 0;
    int hold_len = 1;
    int lat_cnt  = 0;
    int hold_cnt = 0;
    bit armed    = 1'b0;
    int fire_q[$];

    always @(negedge clk) begin
        if (diff_ready) begin
            if (hold_cnt > 1) hold_cnt--;
            else begin
                hold_cnt   = 0;
                diff_ready = 1'b0;
            end
        end else if (!diff_reset && armed) begin
            if (lat_cnt >= latency) begin
                diff_ready       = 1'b1;
                diff_accumulator = d_tab[diff_tau];
                hold_cnt         = hold_len;
                armed            = 1'b0;
                fire_q.push_back(int'(diff_tau));
            end else lat_cnt++;
        end
        if (diff_reset) begin
            armed   = 1'b1;
            lat_cnt = 0;
        end
    end

    // Walk the lags with exact wide arithmetic; d' is compared via cross-multiplication.
    function automatic void refModel(output bit f, output int t, output int nev);
        logic [127:0] s, dd, uu, cd, cs, ct;
        s = '0; cd = '0; cs = '0; ct = '0;
        f = 1'b0; t = 0; nev = 0;
        for (int u = 1; u < MAX_TAU; u++) begin
            dd = 128'(d_tab[u]);
            uu = 128'(u);
            s  = s + dd;
            nev++;
            if (!f) begin
                if (((dd * uu) << THRESH_FRAC) < (128'(THRESHOLD) * s)) begin
                    f = 1'b1; t = u; cd = dd; cs = s; ct = uu;
`ifndef LOCAL_MIN_SEARCH_EN
                    break;
`endif
                end
            end else if ((dd * uu * cs) < (cd * ct * s)) begin
                t = u; cd = dd; cs = s; ct = uu;
            end else break;
        end
    endfunction

    task automatic fillConst(input logic [ACC_WIDTH-1:0] v);
        for (int i = 0; i < 64; i++) d_tab[i] = v;
    endtask

    task automatic fillRandom();
        logic [63:0] r;
        bit big;
        int ndips;
        int p;
        big   = ($urandom % 4) == 0;
        ndips = int'($urandom % 4);
        for (int i = 0; i < 64; i++) begin
            r = {$urandom(), $urandom()};
            d_tab[i] = big ? r[ACC_WIDTH-1:0] : ACC_WIDTH'(500 + ($urandom % 1000));
        end
        for (int k = 0; k < ndips; k++) begin
            p = 1 + int'($urandom % (MAX_TAU - 1));
            d_tab[p] = big ? (d_tab[p] >> 10) : ACC_WIDTH'($urandom % 60);
        end
    endtask

    task automatic applyStimulus(input string name, input logic [ADDR_WIDTH-1:0] addr,
                                 input int lat, input int hold, input bit poke);
        bit exp_f, got_done, addr_ok, busy_ok, seq_ok;
        int exp_t, exp_n, cyc;
        refModel(exp_f, exp_t, exp_n);
        latency  = lat;
        hold_len = hold;
        @(negedge clk);
        fire_q.delete();
        frame_addr = addr;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        frame_addr = ADDR_WIDTH'($urandom);
        checkOutput({name, ":busy_rise"}, 64'(busy), 64'd1);
        checkOutput({name, ":first_tau"}, 64'(diff_tau), 64'd1);
        got_done = 1'b0; addr_ok = 1'b1; busy_ok = 1'b1; cyc = 0;
        while (!got_done && cyc < 6000) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                got_done = 1'b1;
                start    = 1'b0;
                if (busy) busy_ok = 1'b0;
            end else begin
                start = poke && (cyc % 7 == 3);
                if (busy && diff_initial_address !== addr) addr_ok = 1'b0;
            end
        end
        start = 1'b0;
        checkOutput({name, ":done_seen"}, 64'(got_done), 64'd1);
        checkOutput({name, ":found"}, 64'(found), 64'(exp_f));
        checkOutput({name, ":tau_out"}, 64'(tau_out), 64'(exp_t));
        checkOutput({name, ":busy_low_at_done"}, 64'(busy_ok), 64'd1);
        checkOutput({name, ":addr_latched"}, 64'(addr_ok), 64'd1);
        checkOutput({name, ":lags_driven"}, 64'(fire_q.size()), 64'(exp_n));
        seq_ok = 1'b1;
        foreach (fire_q[i]) if (fire_q[i] != i + 1) seq_ok = 1'b0;
        checkOutput({name, ":lag_order"}, 64'(seq_ok), 64'd1);
        @(negedge clk);
        checkOutput({name, ":done_one_cycle"}, 64'(done), 64'd0);
        checkOutput({name, ":found_hold"}, 64'(found), 64'(exp_f));
        checkOutput({name, ":tau_hold"}, 64'(tau_out), 64'(exp_t));
        checkOutput({name, ":idle_after"}, 64'(busy), 64'd0);
    endtask

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cyc;
        bit done_seen;
        fillConst(ACC_WIDTH'(1000));
        repeat (3) @(negedge clk);
        checkOutput("rst:diff_reset", 64'(diff_reset), 64'd1);
        checkOutput("rst:diff_tau", 64'(diff_tau), 64'd0);
        checkOutput("rst:addr", 64'(diff_initial_address), 64'd0);
        checkOutput("rst:busy", 64'(busy), 64'd0);
        checkOutput("rst:done", 64'(done), 64'd0);
        checkOutput("rst:found", 64'(found), 64'd0);
        checkOutput("rst:tau_out", 64'(tau_out), 64'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] directed: single dip at tau 20");
        fillConst(ACC_WIDTH'(1000));
        d_tab[20] = ACC_WIDTH'(10);
        applyStimulus("dip20", 16'h1234, 1, 1, 1'b0);
        checkOutput("dip20:const_tau", 64'(tau_out), 64'd20);
`ifdef LOCAL_MIN_SEARCH_EN
        checkOutput("dip20:const_lags", 64'(fire_q.size()), 64'd21);
`else
        checkOutput("dip20:const_lags", 64'(fire_q.size()), 64'd20);
`endif

        $display("[TB] directed: flat 1000, no pass");
        fillConst(ACC_WIDTH'(1000));
        applyStimulus("flat", 16'h0100, 0, 1, 1'b0);
        checkOutput("flat:const_found", 64'(found), 64'd0);
        checkOutput("flat:const_lags", 64'(fire_q.size()), 64'd39);

        $display("[TB] directed: descending pair at 10/11");
        fillConst(ACC_WIDTH'(1000));
        d_tab[10] = ACC_WIDTH'(50);
        d_tab[11] = ACC_WIDTH'(20);
        d_tab[12] = ACC_WIDTH'(500);
        applyStimulus("pair", 16'h0A0A, 2, 1, 1'b0);
`ifdef LOCAL_MIN_SEARCH_EN
        checkOutput("pair:const_tau", 64'(tau_out), 64'd11);
`else
        checkOutput("pair:const_tau", 64'(tau_out), 64'd10);
`endif

        $display("[TB] directed: all zero");
        fillConst('0);
        applyStimulus("zero", 16'h00FF, 1, 1, 1'b0);
        checkOutput("zero:const_tau", 64'(tau_out), 64'd0);

        $display("[TB] directed: reset inside WAIT at tau 15");
        fillConst(ACC_WIDTH'(1000));
        latency  = 2;
        hold_len = 1;
        @(negedge clk);
        frame_addr = 16'hBEEF;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 0;
        while (!(diff_tau == 15 && !diff_reset && busy) && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("abort:reached_tau15", 64'(diff_tau), 64'd15);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("abort:busy", 64'(busy), 64'd0);
        checkOutput("abort:diff_reset", 64'(diff_reset), 64'd1);
        checkOutput("abort:diff_tau", 64'(diff_tau), 64'd0);
        done_seen = done;
        repeat (5) begin
            @(negedge clk);
            if (done) done_seen = 1'b1;
        end
        checkOutput("abort:no_done", 64'(done_seen), 64'd0);
        checkOutput("abort:stays_idle", 64'(busy), 64'd0);
        d_tab[12] = ACC_WIDTH'(30);
        applyStimulus("restart", 16'h5A5A, 1, 1, 1'b0);

        $display("[TB] directed: ready held 5 cycles, start poked while busy");
        fillConst(ACC_WIDTH'(1000));
        d_tab[7]  = ACC_WIDTH'(900);
        d_tab[25] = ACC_WIDTH'(5);
        d_tab[26] = ACC_WIDTH'(3);
        applyStimulus("hold5", 16'h7777, 0, 5, 1'b1);

        $display("[TB] randomized frames");
        for (int n = 0; n < 10; n++) begin
            fillRandom();
            applyStimulus($sformatf("rand%0d", n), ADDR_WIDTH'($urandom),
                          int'($urandom % 4), 1 + int'($urandom % 3), ($urandom % 2) == 1);
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
